// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multi-cycle RV32I core: steps each instruction through
// fetch/decode/execute/memory/writeback and traps on illegal opcodes or memory timeouts.
module multicycle_control_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  input  logic       branch_taken_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic       alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       bus_error_o
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_U, ALU_WB, MEM_ADR,
    MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JAL, EXEC_JALR, JALR_WB, TRAP
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_r, next_state_s;
  logic              is_load_r, is_load_s;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic              pending_s, timeout_s;

  logic       mem_req_r, mem_we_r, adr_src_r, fetch_r, pc_write_r, reg_write_r;
  logic       alu_src_b_r, done_r, wr_done_r, branch_r, illegal_r, bus_error_r;
  logic [1:0] pc_src_r, result_src_r;
  logic [2:0] alu_op_r;

  // Next-state selection, load/store capture and timeout detection
  always_comb begin
    next_state_s = state_r;
    is_load_s    = is_load_r;
    pending_s    = (state_r == FETCH) || (state_r == MEM_READ) || (state_r == MEM_WRITE);
    timeout_s    = pending_s && !mem_ready_i && (wait_cnt_r == CNT_LAST);
    case (state_r)
      IDLE:  next_state_s = FETCH;
      FETCH, MEM_READ, MEM_WRITE: begin
        if (mem_ready_i) begin
          if (state_r == FETCH) begin
            next_state_s = DECODE;
          end else if (state_r == MEM_READ) begin
            next_state_s = MEM_WB;
          end else begin
            next_state_s = FETCH;
          end
        end else if (timeout_s) begin
          next_state_s = TRAP;
        end else begin
          next_state_s = state_r;
        end
      end
      DECODE: begin
        is_load_s = (opcode_i == OP_LOAD);
        case (opcode_i)
          OP_R:     next_state_s = EXEC_R;
          OP_I:     next_state_s = EXEC_I;
          OP_LUI:   next_state_s = EXEC_U;
          OP_LOAD:  next_state_s = MEM_ADR;
          OP_STORE: next_state_s = MEM_ADR;
          OP_JAL:   next_state_s = JAL;
          OP_JALR:  next_state_s = EXEC_JALR;
          OP_BR:    next_state_s = BRANCH;
          default:  next_state_s = TRAP;
        endcase
      end
      EXEC_R, EXEC_I, EXEC_U: next_state_s = ALU_WB;
      MEM_ADR: begin
        if (is_load_r) begin
          next_state_s = MEM_READ;
        end else begin
          next_state_s = MEM_WRITE;
        end
      end
      EXEC_JALR: next_state_s = JALR_WB;
      ALU_WB, MEM_WB, BRANCH, JAL, JALR_WB: next_state_s = FETCH;
      TRAP:      next_state_s = TRAP;
      default:   next_state_s = IDLE;
    endcase
  end

  // State, wait counter, sticky traps and output registers decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      is_load_r    <= 1'b0;
      wait_cnt_r   <= {CNT_W{1'b0}};
      illegal_r    <= 1'b0;
      bus_error_r  <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      adr_src_r    <= 1'b0;
      fetch_r      <= 1'b0;
      pc_write_r   <= 1'b0;
      pc_src_r     <= 2'b00;
      reg_write_r  <= 1'b0;
      result_src_r <= 2'b00;
      alu_src_b_r  <= 1'b0;
      alu_op_r     <= 3'b000;
      done_r       <= 1'b0;
      wr_done_r    <= 1'b0;
      branch_r     <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      is_load_r <= is_load_s;
      if (pending_s && !mem_ready_i) begin
        if (wait_cnt_r != CNT_MAX) wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= {CNT_W{1'b0}};
      end
      if ((state_r == DECODE) && (next_state_s == TRAP)) illegal_r <= 1'b1;
      if (timeout_s) bus_error_r <= 1'b1;

      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      adr_src_r    <= 1'b0;
      fetch_r      <= 1'b0;
      pc_write_r   <= 1'b0;
      pc_src_r     <= 2'b00;
      reg_write_r  <= 1'b0;
      result_src_r <= 2'b00;
      alu_src_b_r  <= 1'b0;
      alu_op_r     <= 3'b000;
      done_r       <= 1'b0;
      wr_done_r    <= 1'b0;
      branch_r     <= 1'b0;
      case (next_state_s)
        FETCH:     begin mem_req_r <= 1'b1; fetch_r <= 1'b1; end
        EXEC_R:    alu_op_r <= 3'b000;
        EXEC_I:    begin alu_op_r <= 3'b001; alu_src_b_r <= 1'b1; end
        EXEC_U:    begin alu_op_r <= 3'b010; alu_src_b_r <= 1'b1; end
        ALU_WB:    begin reg_write_r <= 1'b1; done_r <= 1'b1; end
        MEM_ADR:   begin alu_op_r <= is_load_s ? 3'b100 : 3'b011; alu_src_b_r <= 1'b1; end
        MEM_READ:  begin mem_req_r <= 1'b1; adr_src_r <= 1'b1; end
        MEM_WB:    begin reg_write_r <= 1'b1; result_src_r <= 2'b01; done_r <= 1'b1; end
        MEM_WRITE: begin mem_req_r <= 1'b1; mem_we_r <= 1'b1; adr_src_r <= 1'b1; wr_done_r <= 1'b1; end
        BRANCH:    begin alu_op_r <= 3'b111; pc_src_r <= 2'b01; branch_r <= 1'b1; done_r <= 1'b1; end
        JAL: begin
          pc_write_r <= 1'b1; pc_src_r <= 2'b01; reg_write_r <= 1'b1;
          result_src_r <= 2'b10; done_r <= 1'b1;
        end
        EXEC_JALR: begin alu_op_r <= 3'b110; alu_src_b_r <= 1'b1; end
        JALR_WB: begin
          pc_write_r <= 1'b1; pc_src_r <= 2'b10; reg_write_r <= 1'b1;
          result_src_r <= 2'b10; done_r <= 1'b1;
        end
        default: mem_req_r <= 1'b0;
      endcase
    end
  end

  // Handshake-qualified terms are the only outputs that see inputs combinationally
  assign ir_write_o   = fetch_r & mem_ready_i;
  assign pc_write_o   = (fetch_r & mem_ready_i) | pc_write_r | (branch_r & branch_taken_i);
  assign instr_done_o = done_r | (wr_done_r & mem_ready_i);
  assign mem_req_o    = mem_req_r;
  assign mem_we_o     = mem_we_r;
  assign adr_src_o    = adr_src_r;
  assign pc_src_o     = pc_src_r;
  assign reg_write_o  = reg_write_r;
  assign result_src_o = result_src_r;
  assign alu_src_b_o  = alu_src_b_r;
  assign alu_op_o     = alu_op_r;
  assign illegal_o    = illegal_r;
  assign bus_error_o  = bus_error_r;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style sequencer for the multi-cycle RV32I core variant. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the ALU_Op code consumed by the ALU control decoder, and the mux selects and write enables of the shared datapath (one ALU, one memory port). It handshakes with memory and traps on illegal opcodes or memory timeouts.

## Interface
- TIMEOUT_CYCLES, 255: max cycles a memory request may wait for `mem_ready_i` before bus error (1..65535)
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the wait counter

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode_i  in  7  instruction[6:0] from the instruction register
- mem_ready_i  in  1  memory completes the current request this cycle
- branch_taken_i  in  1  ALU compare result for the branch in flight
- mem_req_o  out  1  memory request, held until ready
- mem_we_o  out  1  write request (valid with `mem_req_o`)
- adr_src_o  out  1  memory address: 0 = PC, 1 = ALU result register
- ir_write_o  out  1  load instruction register
- pc_write_o  out  1  load PC
- pc_src_o  out  2  00 PC+4, 01 PC+imm, 10 ALU result (LSB forced 0)
- reg_write_o  out  1  register file write
- result_src_o  out  2  00 ALU result register, 01 memory data register, 10 PC+4
- alu_src_b_o  out  1  0 = rs2, 1 = immediate
- alu_op_o  out  3  ALU_Op code
- instr_done_o  out  1  one-cycle pulse when an instruction retires
- illegal_o  out  1  sticky: illegal opcode trap
- bus_error_o  out  1  sticky: memory timeout trap

## Operation
- ALU_Op codes:
  - 000 R-type
  - 001 I-arith
  - 010 LUI
  - 011 store address
  - 100 load address
  - 110 JALR
  - 111 branch
  - 101 is never driven
- Opcode decode in DECODE:
  - 0110011 R-type
  - 0010011 I-arith
  - 0000011 load
  - 0100011 store
  - 0110111 LUI
  - 1101111 JAL
  - 1100111 JALR
  - 1100011 branch
  - anything else → TRAP
- States and transitions:
  - IDLE: entered on reset → FETCH.
  - FETCH: mem_req_o=1, adr_src_o=0. On mem_ready_i: ir_write_o=1 and pc_write_o=1 (pc_src 00), → DECODE.
  - DECODE: no enables asserted. Branches on opcode.
  - EXEC_R: alu_op 000, alu_src_b 0 → ALU_WB.
  - EXEC_I: alu_op 001, alu_src_b 1 → ALU_WB.
  - EXEC_U: alu_op 010, alu_src_b 1 → ALU_WB.
  - ALU_WB: reg_write_o=1, result_src 00, instr_done_o=1 → FETCH.
  - MEM_ADR: alu_op 100 (load) or 011 (store), alu_src_b 1 → MEM_READ or MEM_WRITE.
  - MEM_READ: mem_req_o=1, adr_src_o=1. On ready → MEM_WB.
  - MEM_WB: reg_write_o=1, result_src 01, instr_done_o=1 → FETCH.
  - MEM_WRITE: mem_req_o=1, mem_we_o=1, adr_src_o=1. On ready: instr_done_o=1 → FETCH.
  - BRANCH: alu_op 111, alu_src_b 0, pc_write_o=branch_taken_i, pc_src 01, instr_done_o=1 → FETCH.
  - JAL: pc_write_o=1, pc_src 01, reg_write_o=1, result_src 10, instr_done_o=1 → FETCH.
  - EXEC_JALR: alu_op 110, alu_src_b 1 → JALR_WB.
  - JALR_WB: pc_write_o=1, pc_src 10, reg_write_o=1, result_src 10, instr_done_o=1 → FETCH.
  - TRAP: all enables 0, terminal until reset.
- Load/store opcode is captured into a 1-bit register in DECODE so MEM_ADR can select 100 vs 011.
- Outputs not listed for a state are 0; alu_op_o is 000 outside EXEC/MEM_ADR/BRANCH states.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle the request is pending without ready; saturates at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES with mem_ready_i=0 → TRAP with bus_error_o=1.
  - mem_ready_i on the same cycle the counter reaches the limit wins: no error.
- illegal_o / bus_error_o set on TRAP entry and stay high until reset.

## Timing
- Reset (async): state=IDLE, counter=0. Every output is 0 from reset assertion until one clock after release.
- State register updates on rising clk. Outputs decode the state. Exceptions: the pc_write_o/ir_write_o/instr_done_o terms qualified by mem_ready_i, and pc_write_o in BRANCH, which gates on branch_taken_i.
- Zero-wait-state instruction latency (FETCH→next FETCH):
  - branch 3
  - JAL 3
  - R/I/LUI 4
  - JALR 4
  - store 4
  - load 5
  - Each memory wait cycle adds 1.
- mem_req_o, mem_we_o and adr_src_o are stable while a request is pending. The request drops the cycle after mem_ready_i.
- Reset mid-instruction aborts immediately. No write enable may be high during or in the cycle after reset.

## Test plan
- Reset then R-type (opcode 0110011), mem_ready_i=1 every cycle → states FETCH/DECODE/EXEC_R/ALU_WB, alu_op 000, reg_write_o one cycle at cycle 4, instr_done_o pulse.
- Load with 3 wait cycles in FETCH and 2 in MEM_READ → mem_req_o held 4 and 3 cycles, adr_src_o=1 in MEM_READ, total 10 cycles, result_src 01 at writeback.
- Branch (1100011) with branch_taken_i=0, then again with 1 → pc_write_o low in BRANCH, then high with pc_src 01; alu_op 111 both times.
- Opcode 1111111 → TRAP after DECODE, illegal_o=1, no further mem_req_o until reset; reset clears illegal_o.
- TIMEOUT_CYCLES=4, mem_ready_i held 0 in MEM_WRITE → bus_error_o=1 after 4 pending cycles. Repeat with ready arriving on the 4th cycle → no error, instr_done_o pulse.
- Assert reset during MEM_WRITE wait → all outputs 0 immediately, IDLE then FETCH after release, no stray mem_we_o.
